// File: rtl/irq_pkg.sv
// irq_pkg: shared types and constants for the machine-mode interrupt controller.
//   irq_state_e  - controller FSM states
//   IRQ_*        - bit positions of each source in mip/mie
//   CAUSE_*      - mcause exception codes for each source
//   mk_cause     - builds an mcause value with the interrupt bit set
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        TRAP = 2'd2
    } irq_state_e;

    localparam logic [1:0] IRQ_MSI = 2'd0;
    localparam logic [1:0] IRQ_MTI = 2'd1;
    localparam logic [1:0] IRQ_MEI = 2'd2;

    localparam logic [4:0] CAUSE_MSI = 5'd3;
    localparam logic [4:0] CAUSE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_MEI = 5'd11;

    // Result is 64 bits wide so any XLEN up to 64 can take its low slice;
    // the interrupt flag lands in bit xlen-1 of that slice.
    function automatic logic [63:0] mk_cause(input int unsigned xlen, input logic [4:0] code);
        return (64'd1 << (xlen - 1)) | 64'(code);
    endfunction

endpackage

// File: rtl/irq_ctrl_sync.sv
// irq_ctrl_sync: flop-chain synchronizer for an asynchronous level input.
//   clk    - system clock
//   rst    - asynchronous active-low reset, clears every stage
//   d_i    - asynchronous level
//   q_o    - level after STAGES flops in the clk domain
module irq_ctrl_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-mode interrupt controller.
// Latches/synchronizes the three interrupt sources, masks them with mie and
// mstatus.MIE, picks the RISC-V priority winner (MEI > MSI > MTI) and offers
// it to the pipeline with a req/ack handshake. After ack, no new request is
// raised until the pipeline retires mret.
//   clk, rst        - clock, asynchronous active-low reset
//   timer_irq_i     - one-cycle timer pulse (latched into MTIP)
//   sw_irq_i        - software interrupt level (MSIP)
//   ext_irq_i       - asynchronous external interrupt level (MEIP)
//   mie_global_i    - mstatus.MIE
//   mie_i           - per-source enables {MEIE, MTIE, MSIE}
//   irq_ack_i       - pipeline committed trap entry for the presented cause
//   mret_i          - pipeline retired mret
//   irq_req_o       - trap request
//   irq_cause_o     - mcause for the request (valid while irq_req_o=1)
//   mip_o           - pending bits {MEIP, MTIP, MSIP}
//   in_trap_o       - high between ack and mret
//
// state | meaning
// IDLE  | no request outstanding; latch winner when anything is eligible
// REQ   | request presented, cause frozen until ack or withdrawal
// TRAP  | trap taken; requests blocked until mret
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            timer_irq_i,
    input  logic            sw_irq_i,
    input  logic            ext_irq_i,
    input  logic            mie_global_i,
    input  logic [2:0]      mie_i,
    input  logic            irq_ack_i,
    input  logic            mret_i,
    output logic            irq_req_o,
    output logic [XLEN-1:0] irq_cause_o,
    output logic [2:0]      mip_o,
    output logic            in_trap_o
);

    irq_state_e      state_q, state_d;
    logic [1:0]      src_q, src_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic            mtip_q, mtip_d;
    logic            mtip_clr;
    logic            meip_sync;
    logic [2:0]      eligible;
    logic [1:0]      win_idx;
    logic [4:0]      win_code;

    irq_ctrl_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ext_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ext_irq_i),
        .q_o (meip_sync)
    );

    // MSIP is a pass-through, but is forced low while reset is held so the
    // whole mip read is zero during reset.
    assign mip_o    = {meip_sync, mtip_q, sw_irq_i & rst};
    assign eligible = mip_o & mie_i & {3{mie_global_i}};

    always_comb begin
        win_idx  = IRQ_MTI;
        win_code = CAUSE_MTI;
        if (eligible[IRQ_MEI]) begin
            win_idx  = IRQ_MEI;
            win_code = CAUSE_MEI;
        end else if (eligible[IRQ_MSI]) begin
            win_idx  = IRQ_MSI;
            win_code = CAUSE_MSI;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        cause_d  = cause_q;
        mtip_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = REQ;
                    src_d   = win_idx;
                    cause_d = XLEN'(mk_cause(XLEN, win_code));
                end
            end
            REQ: begin
                if (irq_ack_i) begin
                    state_d  = TRAP;
                    mtip_clr = (src_q == IRQ_MTI);
                end else if (!mie_global_i || !mie_i[src_q]) begin
                    state_d = IDLE;
                end
            end
            TRAP: begin
                if (mret_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new timer pulse in the ack cycle must not be lost: set beats clear.
    always_comb begin
        mtip_d = timer_irq_i | (mtip_q & ~mtip_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            src_q   <= IRQ_MSI;
            cause_q <= '0;
            mtip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            cause_q <= cause_d;
            mtip_q  <= mtip_d;
        end
    end

    assign irq_req_o   = (state_q == REQ);
    assign in_trap_o   = (state_q == TRAP);
    assign irq_cause_o = cause_q;

endmodule
